// File: rtl/cla_sub_32bit_pipe.sv
// 32-bit subtractor (a - b - borrow_in) built from two 16-bit carry-lookahead halves,
// split across a two-stage valid/ready pipeline with full backpressure.
module cla_sub_32bit_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        borrow_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] diff,
    output logic        borrow_out,
    output logic        overflow,
    output logic        zero
);
    localparam int DATA_W = 32;
    localparam int HALF_W = DATA_W / 2;

    // 16-bit adder: four 4-bit lookahead groups, groups chained by group generate/propagate.
    // Returns {carry_out, sum}.
    function automatic logic [HALF_W:0] cla16(input logic [HALF_W-1:0] x,
                                              input logic [HALF_W-1:0] y,
                                              input logic              cin);
        logic [HALF_W-1:0] g;
        logic [HALF_W-1:0] p;
        logic [HALF_W-1:0] c;
        logic [3:0]        gg;
        logic [3:0]        gp;
        logic [4:0]        gc;
        g     = x & y;
        p     = x ^ y;
        gc[0] = cin;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int i = 1; i < 4; i++) begin
                c[4*k+i] = g[4*k+i-1] | (p[4*k+i-1] & c[4*k+i-1]);
            end
        end
        return {gc[4], p ^ c};
    endfunction

    logic              vld_p1;
    logic              vld_p2;
    logic              adv_p1;
    logic              adv_p2;
    logic [HALF_W-1:0] dlo_p1;
    logic [HALF_W-1:0] ahi_p1;
    logic [HALF_W-1:0] nbhi_p1;
    logic              c16_p1;
    logic [HALF_W:0]   lo_sum;
    logic [HALF_W:0]   hi_sum;
    logic [DATA_W-1:0] diff_nx;
    logic              ovf_nx;
    logic [DATA_W-1:0] diff_p2;
    logic              bout_p2;
    logic              ovf_p2;
    logic              zero_p2;

    assign adv_p2   = !vld_p2 || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = adv_p1;

    // Stage 1: low half, subtraction as a + ~b + ~borrow_in
    assign lo_sum = cla16(a[HALF_W-1:0], ~b[HALF_W-1:0], ~borrow_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            dlo_p1  <= lo_sum[HALF_W-1:0];
            c16_p1  <= lo_sum[HALF_W];
            ahi_p1  <= a[DATA_W-1:HALF_W];
            nbhi_p1 <= ~b[DATA_W-1:HALF_W];
        end
    end

    // Stage 2: high half and flags; sign of b is recovered from the inverted copy
    assign hi_sum  = cla16(ahi_p1, nbhi_p1, c16_p1);
    assign diff_nx = {hi_sum[HALF_W-1:0], dlo_p1};
    assign ovf_nx  = (ahi_p1[HALF_W-1] != ~nbhi_p1[HALF_W-1])
                  && (diff_nx[DATA_W-1] != ahi_p1[HALF_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            diff_p2 <= '0;
            bout_p2 <= 1'b0;
            ovf_p2  <= 1'b0;
            zero_p2 <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                diff_p2 <= diff_nx;
                bout_p2 <= ~hi_sum[HALF_W];
                ovf_p2  <= ovf_nx;
                zero_p2 <= (diff_nx == '0);
            end
        end
    end

    assign out_valid  = vld_p2;
    assign diff       = diff_p2;
    assign borrow_out = bout_p2;
    assign overflow   = ovf_p2;
    assign zero       = zero_p2;
endmodule

// File: tb/tb_cla_sub_32bit_pipe.sv
// Bench for cla_sub_32bit_pipe: directed vectors, backpressure, back-to-back random stream
// and mid-flight reset, all scored against an arithmetic reference model.
module tb_cla_sub_32bit_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow_out;
    logic        overflow;
    logic        zero;

    int n_chk = 0;
    int n_err = 0;
    logic [34:0] exp_q[$];

    cla_sub_32bit_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .borrow_in(borrow_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {diff, borrow_out, overflow, zero} from plain unsigned/signed arithmetic.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic bi);
        logic [32:0] u;
        longint      s;
        logic        ovf;
        u   = {1'b0, x} - {1'b0, y} - {32'd0, bi};
        s   = longint'($signed(x)) - longint'($signed(y)) - longint'({31'd0, bi});
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {u[31:0], u[32], ovf, (u[31:0] == 32'd0)};
    endfunction

    // One cycle: drive at negedge, sample 1 time unit later, well before the next rising edge.
    task automatic step(input logic v, input logic [31:0] x, input logic [31:0] y,
                        input logic bi, input logic ordy, output logic acc, output logic ov);
        @(negedge clk);
        in_valid  = v;
        a         = x;
        b         = y;
        borrow_in = bi;
        out_ready = ordy;
        #1;
        ov = out_valid;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                chk("result", {29'd0, diff, borrow_out, overflow, zero}, {29'd0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(x, y, bi));
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic bi, input logic ordy);
        logic acc;
        logic ov;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            step(1'b1, x, y, bi, ordy, acc, ov);
            n++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        logic acc;
        logic ov;
        int   n;
        n  = 0;
        ov = 1'b1;
        while ((exp_q.size() != 0 || ov) && n < 20) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc, ov);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic        ov;
        int          accepted;
        logic [31:0] bp_a[4];
        logic [31:0] bp_b[4];

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_borrow", 64'(borrow_out), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // Latency: accepted at edge N, visible after edge N+1
        send(32'd5, 32'd3, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc, ov);
        chk("lat_stage1", 64'(ov), 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc, ov);
        chk("lat_stage2", 64'(ov), 64'd1);
        drain();

        send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        send(32'h0001_0000, 32'h0000_0001, 1'b1, 1'b1);
        send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();

        // Backpressure: only two operand sets fit while the output is stalled
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
        end
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, bp_a[accepted], bp_b[accepted], 1'b0, 1'b0, acc, ov);
            if (acc) accepted++;
        end
        chk("bp_accepted", 64'(accepted), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        while (accepted < 4) begin
            send(bp_a[accepted], bp_b[accepted], 1'b0, 1'b1);
            accepted++;
        end
        drain();

        // Back-to-back stream
        for (int i = 0; i < 100; i++) begin
            step(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 1'b1, acc, ov);
            chk("b2b_accept", 64'(acc), 64'd1);
            if (i >= 2) chk("b2b_out_valid", 64'(ov), 64'd1);
        end
        drain();

        // Reset with both stages full
        send($urandom, $urandom, 1'b0, 1'b0);
        send($urandom, $urandom, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_rel_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc, ov);
            chk("midrst_quiet", 64'(ov), 64'd0);
        end

        send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1);
        drain();
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
